// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter scheduler slice.
//   - state_t      : 2-bit FSM state encoding (IDLE, LOAD, COUNT, DONE)
//   - N_REQ_DEF    : default number of requesters
//   - WIDTH_DEF    : default counter / load-value width
package counter_scheduler_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester-side bus of the counter scheduler.
//   req      : per-requester level request, held until done
//   load_bus : requester i load value at [i*WIDTH +: WIDTH]
//   gnt      : one-hot grant, zero when idle
//   done     : one-cycle completion pulse to the granted requester
//   busy     : scheduler is not idle
//   cnt      : current value of the shared down-counter
// master = requesters, slave = scheduler.
interface counter_scheduler_if
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] load_bus;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [WIDTH-1:0]       cnt;

  modport master (
    output req, load_bus,
    input  gnt, done, busy, cnt
  );

  modport slave (
    input  req, load_bus,
    output gnt, done, busy, cnt
  );

endinterface

// File: rtl/counter_scheduler_down_counter.sv
// Loadable down-counter that saturates at zero.
//   clk, rst : clock, asynchronous active-high reset
//   ld       : load din (has priority over dec)
//   dec      : decrement by one unless already zero
//   din      : load value
//   q        : registered count
module down_counter
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Count register; the zero guard keeps the value from wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= din;
    end else if (dec && (q != '0)) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler that lends one shared down-counter to N_REQ requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester bus (slave side), see counter_scheduler_if
// A granted requester gets its load value counted down to zero; the done
// pulse appears on the edge that leaves DONE, together with the grant clear.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_scheduler_if.slave   bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [WIDTH-1:0] cnt_q;

  logic [IW-1:0]    cand;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic [IW-1:0]    rr_next;
  logic [WIDTH-1:0] load_val;
  logic             held;
  logic             abort;
  logic             ld;
  logic             dec;
  logic [WIDTH-1:0] din;

  // Cyclic first-set search starting at rr_ptr.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(rr_ptr_q) + i) % N_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Granted requester's load slice, selected with constant part-selects.
  always_comb begin
    load_val = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx_q == IW'(i)) begin
        load_val = bus.load_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // Counter control; an abort reloads zero so cnt reads 0 back in IDLE.
  always_comb begin
    held    = bus.req[gidx_q];
    abort   = ((state == ST_LOAD) || (state == ST_COUNT)) && !held;
    ld      = abort || (state == ST_LOAD);
    din     = abort ? '0 : load_val;
    dec     = (state == ST_COUNT) && held;
    rr_next = IW'((32'(gidx_q) + 32'd1) % N_REQ);
  end

  down_counter #(
    .WIDTH (WIDTH)
  ) u_down_counter (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .dec (dec),
    .din (din),
    .q   (cnt_q)
  );

  // Scheduler FSM with registered grant, done and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q  <= N_REQ'(1) << pick;
            gidx_q <= pick;
            busy_q <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD, ST_COUNT: begin
          if (abort) begin
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_next;
            state    <= ST_IDLE;
          end else if (state == ST_LOAD) begin
            state <= ST_COUNT;
          end else if (cnt_q == '0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q   <= gnt_q;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_next;
          state    <= ST_IDLE;
        end
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: reset, round-robin order, single
// request latency, zero load, abort, asynchronous reset and maximum load.
module tb_counter_scheduler;
  import counter_scheduler_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 4;

  logic        clk;
  logic        rst;
  int unsigned passed = 0;
  int unsigned total  = 0;
  int          order [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  oh;

  counter_scheduler_if #(.N_REQ(NR), .WIDTH(W)) bus ();

  counter_scheduler #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  16'(bus.gnt),  16'h0);
    chk({tag, "_done"}, 16'(bus.done), 16'h0);
    chk({tag, "_busy"}, 16'(bus.busy), 16'h0);
    chk({tag, "_cnt"},  16'(bus.cnt),  16'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.load_bus = '0;
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // Round-robin with every requester holding, all loads 1.
    bus.req      = 4'b1111;
    bus.load_bus = 16'h1111;
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << order[n];
      tick();
      chk("rr_gnt", 16'(bus.gnt), 16'(oh));
      chk("rr_nodone_a", 16'(bus.done), 16'h0);
      tick();
      chk("rr_cnt1", 16'(bus.cnt), 16'h1);
      tick();
      chk("rr_cnt0", 16'(bus.cnt), 16'h0);
      tick();
      chk("rr_gnt_done_state", 16'(bus.gnt), 16'(oh));
      chk("rr_nodone_b", 16'(bus.done), 16'h0);
      tick();
      chk("rr_done", 16'(bus.done), 16'(oh));
      chk("rr_gnt_clr", 16'(bus.gnt), 16'h0);
    end
    bus.req = '0;
    tick();
    chk_idle("rr_end");

    // Single request, load 2: done after edge k+5.
    bus.req      = 4'b0001;
    bus.load_bus = 16'h0002;
    tick();
    chk("s_gnt", 16'(bus.gnt), 16'h1);
    chk("s_busy", 16'(bus.busy), 16'h1);
    tick();
    chk("s_cnt2", 16'(bus.cnt), 16'h2);
    tick();
    chk("s_cnt1", 16'(bus.cnt), 16'h1);
    tick();
    chk("s_cnt0", 16'(bus.cnt), 16'h0);
    tick();
    chk("s_nodone", 16'(bus.done), 16'h0);
    chk("s_gnt_hold", 16'(bus.gnt), 16'h1);
    tick();
    chk("s_done", 16'(bus.done), 16'h1);
    chk("s_gnt_clr", 16'(bus.gnt), 16'h0);
    bus.req = '0;
    tick();
    chk_idle("s_end");

    // Zero load on requester 2: done after edge k+3.
    bus.req      = 4'b0100;
    bus.load_bus = 16'h0000;
    tick();
    chk("z_gnt", 16'(bus.gnt), 16'h4);
    tick();
    chk("z_cnt_a", 16'(bus.cnt), 16'h0);
    tick();
    chk("z_nodone", 16'(bus.done), 16'h0);
    chk("z_cnt_b", 16'(bus.cnt), 16'h0);
    tick();
    chk("z_done", 16'(bus.done), 16'h4);
    chk("z_cnt_c", 16'(bus.cnt), 16'h0);
    bus.req = '0;
    tick();

    // Abort requester 1 at cnt=5; next scan starts at requester 2.
    bus.req      = 4'b0010;
    bus.load_bus = 16'h0090;
    tick();
    chk("a_gnt", 16'(bus.gnt), 16'h2);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("a_cnt", 16'(bus.cnt), 16'(10 - j));
    end
    bus.req = '0;
    tick();
    chk_idle("a_abort");
    tick();
    chk("a_nodone", 16'(bus.done), 16'h0);
    bus.req      = 4'b0011;
    bus.load_bus = 16'h0001;
    tick();
    chk("a_next_gnt", 16'(bus.gnt), 16'h1);
    bus.req = '0;
    tick();
    chk_idle("a_load_abort");
    tick();
    chk("a_nodone2", 16'(bus.done), 16'h0);

    // Asynchronous reset during COUNT with cnt=6.
    bus.req      = 4'b1000;
    bus.load_bus = 16'h6000;
    tick();
    chk("r_gnt", 16'(bus.gnt), 16'h8);
    tick();
    chk("r_cnt6", 16'(bus.cnt), 16'h6);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("r_async");
    #3;
    rst     = 1'b0;
    bus.req = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_idle("r_release");
    end

    // Maximum load 15 on requester 3: done after edge k+18.
    bus.req      = 4'b1000;
    bus.load_bus = 16'hF000;
    tick();
    chk("m_gnt", 16'(bus.gnt), 16'h8);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk("m_cnt", 16'(bus.cnt), 16'(16 - j));
      chk("m_nodone", 16'(bus.done), 16'h0);
    end
    tick();
    chk("m_cnt_done_state", 16'(bus.cnt), 16'h0);
    chk("m_nodone_done_state", 16'(bus.done), 16'h0);
    tick();
    chk("m_done", 16'(bus.done), 16'h8);
    chk("m_cnt_nowrap", 16'(bus.cnt), 16'h0);
    bus.req = '0;
    tick();
    chk_idle("m_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
